unified_issue_queue_param: RTL and testbench
============================================

// Module: unified_issue_queue_param
// PURPOSE
// - Parametrised successor issue queue between rename/dispatch and the FU pool of the OoO RISC-V core.
// - Buffers up to RS_SIZE renamed µops and captures operands from the ARF at dispatch or from NUM_CDB result buses.
// - Issues ready µops, up to one per FU per cycle, to NUM_FU registered issue ports.
// - Adds over the previous queue: valid/ready dispatch handshake, occupancy/full/empty, flush, same-cycle CDB bypass, and parametrised FU/CDB counts.
// PARAMETERS
// RS_SIZE   16  entries; power of 2, 4..64
// AR_SIZE   6   physical tag width
// NUM_FU    3   FUs/issue ports, 1..4
// FU_SIZE   2   FU index width, clog2(NUM_FU) min 1
// NUM_CDB   3   wakeup/result buses
// PORTS
// clk              in   1                 clock, rising edge
// rstn             in   1                 reset, synchronous, ACTIVE-HIGH (1 = reset); name kept per codebase
// flush_in         in   1                 squash all entries
// disp_valid_in    in   1                 dispatch request
// disp_ready_out   out  1                 queue can accept
// opcode_in        in   7                 RV opcode
// funct3_in        in   3                 RV funct3
// rd_in/rs1_in/rs2_in in AR_SIZE each     physical tags
// rs1_rdy_in,rs2_rdy_in in 1 each         operand valid in ARF
// rs1_val_in,rs2_val_in,imm_in in 32 each ARF values, immediate
// cdb_valid_in     in   NUM_CDB           bus k broadcasting
// cdb_tag_in       in   NUM_CDB*AR_SIZE   tag k at [k*AR_SIZE +: AR_SIZE]
// cdb_value_in     in   NUM_CDB*32        value k at [k*32 +: 32]
// fu_ready_in      in   NUM_FU            FU f accepts this cycle
// issue_valid_out  out  NUM_FU            port f carries a µop
// issue_op_out     out  NUM_FU*4          op code per port
// issue_rd_out     out  NUM_FU*AR_SIZE    dest tag per port
// issue_rs1_val_out,issue_rs2_val_out,issue_imm_out out NUM_FU*32 each  operands per port
// count_out        out  clog2(RS_SIZE)+1  occupancy
// full_out,empty_out out 1 each           count==RS_SIZE / count==0
// BEHAVIOUR
// - Reset (rstn=1 at edge): all entries invalid; rr_ptr=0; every output 0 except empty_out=1.
//   disp_ready_out=0 while rstn=1. Reset mid-operation drops all queued µops.
// - Decode: ADD=1 ADDI=2 LUI=3 ORI=4 XOR=5 SRAI=6 LB=7 LW=8 SB=9 SW=10.
//   Any other encoding is queued as op 0 (NOP) and issued normally.
// - disp_ready_out = !rstn && !flush_in && count<RS_SIZE. It depends on registered count only:
//   entries freed by issue in the same cycle do not raise it.
// - Accept (valid&&ready): write the lowest-index free entry. FU id = rr_ptr.
//   rr_ptr then increments, wrapping NUM_FU-1 -> 0.
// - Operand capture at dispatch, priority ARF ready > lowest-index matching CDB > wait.
//   A same-cycle CDB match is a bypass: the operand is captured ready with the CDB value.
// - Wakeup: each valid, not-ready operand whose tag matches an active CDB becomes ready at the edge.
//   Duplicate tags resolve to the lowest k. Ready operands are never overwritten.
// - Select evaluates registered state: entry valid, both operands ready, fu_ready_in[fu] set, FU not yet taken.
//   At most one entry per FU per cycle.
//   - Dispatch at edge t: earliest issue at edge t+1.
//   - Wakeup at edge t: earliest issue at edge t+1.
// - Issue latency 1: an entry selected in cycle t is freed at edge t. Port outputs are registered and valid during t+1.
//   With nothing selected, issue_valid_out[f]=0 and the data fields hold their last values.
// - count_next = count + accepted - issued. Simultaneous dispatch and issue when full: the issue frees, the dispatch is refused.
// - Flush beats dispatch and issue: all entries invalid, issue_valid_out=0 next cycle, count=0. rr_ptr is kept.
// CONFIGURATION
// - UIQ_AGE_SELECT_EN defined: per-FU select picks the oldest eligible entry.
//   Each entry carries a dispatch-order stamp; ties are impossible.
// - Undefined: per-FU select picks the lowest-index eligible entry. No age storage is built.
// TESTING
// - rstn=1 for 2 cycles, then 0 -> all issue_valid_out=0, count_out=0, empty_out=1; disp_ready_out=1 after release.
// - Dispatch ADD rd=5 rs1=1,rs2=2, both ARF ready (vals 3,4), fu_ready=3'b111 -> port 0 valid 2 cycles after accept, op=1, vals 3/4.
// - Dispatch rs1=9 not ready; CDB0 tag=9 val=0xAA two cycles later -> issues the next cycle with rs1_val=0xAA.
//   A repeat with the CDB in the dispatch cycle (bypass) issues 1 cycle after accept.
// - Fill RS_SIZE entries with fu_ready=0 -> full_out=1, disp_ready_out=0, count=RS_SIZE.
//   Raise fu_ready=3'b111 -> three issues per cycle until empty.
// - 3 ready µops on FU0 and fu_ready=3'b001 -> one issue per cycle in order (oldest-first when UIQ_AGE_SELECT_EN is defined).
// - flush_in with 5 queued and a simultaneous dispatch -> count=0, no issue next cycle, dispatch dropped.

Source files
------------

// File: rtl/unified_issue_queue_param_if.sv
// Dispatch, CDB, FU-ready and issue-port bundle for unified_issue_queue_param.
// master drives dispatch/CDB/fu_ready (dispatch stage side); slave is the queue.
interface unified_issue_queue_param_if #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned AR_SIZE = 6,
    parameter int unsigned NUM_FU  = 3,
    parameter int unsigned NUM_CDB = 3
);
    localparam int unsigned CntW = $clog2(RS_SIZE) + 1;

    logic                      flush_in;
    logic                      disp_valid_in;
    logic                      disp_ready_out;
    logic [6:0]                opcode_in;
    logic [2:0]                funct3_in;
    logic [AR_SIZE-1:0]        rd_in;
    logic [AR_SIZE-1:0]        rs1_in;
    logic [AR_SIZE-1:0]        rs2_in;
    logic                      rs1_rdy_in;
    logic                      rs2_rdy_in;
    logic [31:0]               rs1_val_in;
    logic [31:0]               rs2_val_in;
    logic [31:0]               imm_in;
    logic [NUM_CDB-1:0]        cdb_valid_in;
    logic [NUM_CDB*AR_SIZE-1:0] cdb_tag_in;
    logic [NUM_CDB*32-1:0]     cdb_value_in;
    logic [NUM_FU-1:0]         fu_ready_in;
    logic [NUM_FU-1:0]         issue_valid_out;
    logic [NUM_FU*4-1:0]       issue_op_out;
    logic [NUM_FU*AR_SIZE-1:0] issue_rd_out;
    logic [NUM_FU*32-1:0]      issue_rs1_val_out;
    logic [NUM_FU*32-1:0]      issue_rs2_val_out;
    logic [NUM_FU*32-1:0]      issue_imm_out;
    logic [CntW-1:0]           count_out;
    logic                      full_out;
    logic                      empty_out;

    modport master (
        output flush_in, disp_valid_in, opcode_in, funct3_in, rd_in, rs1_in, rs2_in,
               rs1_rdy_in, rs2_rdy_in, rs1_val_in, rs2_val_in, imm_in,
               cdb_valid_in, cdb_tag_in, cdb_value_in, fu_ready_in,
        input  disp_ready_out, issue_valid_out, issue_op_out, issue_rd_out,
               issue_rs1_val_out, issue_rs2_val_out, issue_imm_out, count_out, full_out, empty_out
    );

    modport slave (
        input  flush_in, disp_valid_in, opcode_in, funct3_in, rd_in, rs1_in, rs2_in,
               rs1_rdy_in, rs2_rdy_in, rs1_val_in, rs2_val_in, imm_in,
               cdb_valid_in, cdb_tag_in, cdb_value_in, fu_ready_in,
        output disp_ready_out, issue_valid_out, issue_op_out, issue_rd_out,
               issue_rs1_val_out, issue_rs2_val_out, issue_imm_out, count_out, full_out, empty_out
    );
endinterface

// File: rtl/unified_issue_queue_param.sv
// Unified issue queue: buffers renamed uops, captures operands from ARF/CDB, issues per FU.
// Define UIQ_AGE_SELECT_EN for oldest-first select; otherwise lowest-index select.
module unified_issue_queue_param #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned AR_SIZE = 6,
    parameter int unsigned NUM_FU  = 3,
    parameter int unsigned FU_SIZE = 2,
    parameter int unsigned NUM_CDB = 3
) (
    input logic                        clk,
    input logic                        rstn,
    unified_issue_queue_param_if.slave uiq
);
    localparam int unsigned IdxW = $clog2(RS_SIZE);
    localparam int unsigned CntW = IdxW + 1;

    logic [RS_SIZE-1:0] vld_q, vld_d, rdy1_q, rdy2_q, freed;
    logic [3:0]         op_q   [RS_SIZE];
    logic [AR_SIZE-1:0] rd_q   [RS_SIZE];
    logic [AR_SIZE-1:0] tag1_q [RS_SIZE];
    logic [AR_SIZE-1:0] tag2_q [RS_SIZE];
    logic [31:0]        val1_q [RS_SIZE];
    logic [31:0]        val2_q [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [FU_SIZE-1:0] fu_q   [RS_SIZE];
    logic [32:0]        wake1  [RS_SIZE];
    logic [32:0]        wake2  [RS_SIZE];
    logic [32:0]        byp1, byp2;
    logic [FU_SIZE-1:0] rr_q, rr_d;
    logic [CntW-1:0]    count_q, count_d, iss_cnt;
    logic               disp_ready, accept;
    logic [IdxW-1:0]    free_idx;
    logic [RS_SIZE-1:0] elig    [NUM_FU];
    logic [NUM_FU-1:0]  sel_vld, iss_vld_q;
    logic [IdxW-1:0]    sel_idx [NUM_FU];
    logic [3:0]         iss_op_q  [NUM_FU];
    logic [AR_SIZE-1:0] iss_rd_q  [NUM_FU];
    logic [31:0]        iss_v1_q  [NUM_FU];
    logic [31:0]        iss_v2_q  [NUM_FU];
    logic [31:0]        iss_imm_q [NUM_FU];
`ifdef UIQ_AGE_SELECT_EN
    // older_q[j][i] set: entry j was dispatched before entry i.
    logic [RS_SIZE-1:0] older_q [RS_SIZE];
    logic               blocked;
`endif

    // {hit, value}; lowest-numbered matching bus wins.
    function automatic logic [32:0] cdb_hit(input logic [AR_SIZE-1:0] tag,
                                            input logic [NUM_CDB-1:0] v,
                                            input logic [NUM_CDB*AR_SIZE-1:0] t,
                                            input logic [NUM_CDB*32-1:0] d);
        logic [32:0] r;
        r = '0;
        for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
            if (v[k] && t[k*AR_SIZE +: AR_SIZE] == tag) r = {1'b1, d[k*32 +: 32]};
        end
        return r;
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] opc, input logic [2:0] f3);
        logic [3:0] op;
        op = 4'd0;
        case (opc)
            7'b0110011: if (f3 == 3'b000) op = 4'd1; else if (f3 == 3'b100) op = 4'd5;
            7'b0010011: if (f3 == 3'b000) op = 4'd2; else if (f3 == 3'b110) op = 4'd4;
                        else if (f3 == 3'b101) op = 4'd6;
            7'b0110111: op = 4'd3;
            7'b0000011: if (f3 == 3'b000) op = 4'd7; else if (f3 == 3'b010) op = 4'd8;
            7'b0100011: if (f3 == 3'b000) op = 4'd9; else if (f3 == 3'b010) op = 4'd10;
            default:    op = 4'd0;
        endcase
        return op;
    endfunction

    assign disp_ready         = !rstn && !uiq.flush_in && (count_q < CntW'(RS_SIZE));
    assign accept             = uiq.disp_valid_in && disp_ready;
    assign uiq.disp_ready_out = disp_ready;
    assign uiq.count_out      = count_q;
    assign uiq.full_out       = (count_q == CntW'(RS_SIZE));
    assign uiq.empty_out      = (count_q == '0);
    assign uiq.issue_valid_out = iss_vld_q;

    // Per-FU select over registered state; flush suppresses all issue.
    always_comb begin
        for (int f = 0; f < int'(NUM_FU); f++) begin
            sel_vld[f] = 1'b0;
            sel_idx[f] = '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                elig[f][i] = vld_q[i] && rdy1_q[i] && rdy2_q[i] && (fu_q[i] == FU_SIZE'(f)) &&
                             uiq.fu_ready_in[f] && !uiq.flush_in;
            end
`ifdef UIQ_AGE_SELECT_EN
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                blocked = 1'b0;
                for (int j = 0; j < int'(RS_SIZE); j++) blocked = blocked | (elig[f][j] & older_q[j][i]);
                if (elig[f][i] && !blocked) begin
                    sel_vld[f] = 1'b1;
                    sel_idx[f] = IdxW'(i);
                end
            end
`else
            for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
                if (elig[f][i]) begin
                    sel_vld[f] = 1'b1;
                    sel_idx[f] = IdxW'(i);
                end
            end
`endif
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) if (!vld_q[i]) free_idx = IdxW'(i);
        freed   = '0;
        iss_cnt = '0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            if (sel_vld[f]) begin
                freed[sel_idx[f]] = 1'b1;
                iss_cnt = iss_cnt + CntW'(1);
            end
        end
        if (uiq.flush_in) begin
            vld_d   = '0;
            count_d = '0;
        end else begin
            vld_d = vld_q & ~freed;
            if (accept) vld_d[free_idx] = 1'b1;
            count_d = count_q + CntW'(accept) - iss_cnt;
        end
        rr_d = rr_q;
        if (accept) rr_d = (rr_q == FU_SIZE'(NUM_FU - 1)) ? '0 : rr_q + FU_SIZE'(1);
        byp1 = cdb_hit(uiq.rs1_in, uiq.cdb_valid_in, uiq.cdb_tag_in, uiq.cdb_value_in);
        byp2 = cdb_hit(uiq.rs2_in, uiq.cdb_valid_in, uiq.cdb_tag_in, uiq.cdb_value_in);
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            wake1[i] = cdb_hit(tag1_q[i], uiq.cdb_valid_in, uiq.cdb_tag_in, uiq.cdb_value_in);
            wake2[i] = cdb_hit(tag2_q[i], uiq.cdb_valid_in, uiq.cdb_tag_in, uiq.cdb_value_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_q     <= '0;
            count_q   <= '0;
            rr_q      <= '0;
            iss_vld_q <= '0;
            for (int f = 0; f < int'(NUM_FU); f++) begin
                iss_op_q[f]  <= '0;
                iss_rd_q[f]  <= '0;
                iss_v1_q[f]  <= '0;
                iss_v2_q[f]  <= '0;
                iss_imm_q[f] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            iss_vld_q <= sel_vld;
            for (int f = 0; f < int'(NUM_FU); f++) begin
                if (sel_vld[f]) begin
                    iss_op_q[f]  <= op_q[sel_idx[f]];
                    iss_rd_q[f]  <= rd_q[sel_idx[f]];
                    iss_v1_q[f]  <= val1_q[sel_idx[f]];
                    iss_v2_q[f]  <= val2_q[sel_idx[f]];
                    iss_imm_q[f] <= imm_q[sel_idx[f]];
                end
            end
        end
    end

    // Entry payload; validity is tracked in vld_q so no reset is needed here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (accept && free_idx == IdxW'(i)) begin
                op_q[i]   <= decode(uiq.opcode_in, uiq.funct3_in);
                rd_q[i]   <= uiq.rd_in;
                tag1_q[i] <= uiq.rs1_in;
                tag2_q[i] <= uiq.rs2_in;
                imm_q[i]  <= uiq.imm_in;
                fu_q[i]   <= rr_q;
                rdy1_q[i] <= uiq.rs1_rdy_in || byp1[32];
                rdy2_q[i] <= uiq.rs2_rdy_in || byp2[32];
                val1_q[i] <= uiq.rs1_rdy_in ? uiq.rs1_val_in : byp1[31:0];
                val2_q[i] <= uiq.rs2_rdy_in ? uiq.rs2_val_in : byp2[31:0];
            end else begin
                if (!rdy1_q[i] && wake1[i][32]) begin
                    rdy1_q[i] <= 1'b1;
                    val1_q[i] <= wake1[i][31:0];
                end
                if (!rdy2_q[i] && wake2[i][32]) begin
                    rdy2_q[i] <= 1'b1;
                    val2_q[i] <= wake2[i][31:0];
                end
            end
        end
    end

`ifdef UIQ_AGE_SELECT_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < int'(RS_SIZE); j++) older_q[j][free_idx] <= vld_q[j];
            older_q[free_idx] <= '0;
        end
    end
`endif

    always_comb begin
        for (int f = 0; f < int'(NUM_FU); f++) begin
            uiq.issue_op_out[f*4 +: 4]               = iss_op_q[f];
            uiq.issue_rd_out[f*AR_SIZE +: AR_SIZE]   = iss_rd_q[f];
            uiq.issue_rs1_val_out[f*32 +: 32]        = iss_v1_q[f];
            uiq.issue_rs2_val_out[f*32 +: 32]        = iss_v2_q[f];
            uiq.issue_imm_out[f*32 +: 32]            = iss_imm_q[f];
        end
    end
endmodule

// File: tb/tb_unified_issue_queue_param.sv
// Scoreboard bench for unified_issue_queue_param: directed dispatch vectors push expected
// issues; a negedge monitor pops and compares whatever the issue ports present.
module tb_unified_issue_queue_param;
    localparam int RS = 16, AR = 6, NF = 3, NC = 3;

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0, errors = 0, cyc = 0, exp_rr = 0;
    exp_t sb[$];

    logic [6:0] t_opc [11] = '{7'h33, 7'h13, 7'h37, 7'h13, 7'h33, 7'h13, 7'h03, 7'h03, 7'h23,
                               7'h23, 7'h63};
    logic [2:0] t_f3  [11] = '{3'd0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd5, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
    logic [3:0] t_op  [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd0};

    unified_issue_queue_param_if #(.RS_SIZE(RS), .AR_SIZE(AR), .NUM_FU(NF), .NUM_CDB(NC)) bus ();

    unified_issue_queue_param #(
        .RS_SIZE(RS), .AR_SIZE(AR), .NUM_FU(NF), .FU_SIZE(2), .NUM_CDB(NC)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .uiq (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int p, input logic [3:0] op, input logic [5:0] rd,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input int c);
        exp_t e;
        e.port = p; e.op = op; e.rd = rd; e.v1 = v1; e.v2 = v2; e.imm = imm; e.cyc = c;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic disp(input logic [6:0] opc, input logic [2:0] f3, input logic [5:0] rd,
                        input logic [5:0] rs1, input logic [5:0] rs2, input logic r1,
                        input logic r2, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, output int port, output int acc);
        int n;
        bus.disp_valid_in = 1'b1;
        bus.opcode_in = opc; bus.funct3_in = f3; bus.rd_in = rd;
        bus.rs1_in = rs1; bus.rs2_in = rs2; bus.rs1_rdy_in = r1; bus.rs2_rdy_in = r2;
        bus.rs1_val_in = v1; bus.rs2_val_in = v2; bus.imm_in = imm;
        n = 0;
        #1;
        while (!bus.disp_ready_out && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.disp_ready_out) begin
            checks++;
            errors++;
            $display("FAIL disp_timeout ready=0 required=1");
        end
        port   = exp_rr;
        acc    = cyc;
        exp_rr = (exp_rr + 1) % NF;
        @(negedge clk);
        bus.disp_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        int   idx;
        exp_t e;
        if (!rstn) begin
            for (int f = 0; f < NF; f++) begin
                if (bus.issue_valid_out[f]) begin
                    idx = -1;
                    for (int q = 0; q < sb.size(); q++) if (idx < 0 && sb[q].port == f) idx = q;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_issue port=%0d rd=%0d required=no_issue", f,
                                 bus.issue_rd_out[f*AR +: AR]);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        chk("issue_op", 64'(bus.issue_op_out[f*4 +: 4]), 64'(e.op));
                        chk("issue_rd", 64'(bus.issue_rd_out[f*AR +: AR]), 64'(e.rd));
                        chk("issue_rs1", 64'(bus.issue_rs1_val_out[f*32 +: 32]), 64'(e.v1));
                        chk("issue_rs2", 64'(bus.issue_rs2_val_out[f*32 +: 32]), 64'(e.v2));
                        chk("issue_imm", 64'(bus.issue_imm_out[f*32 +: 32]), 64'(e.imm));
                        if (e.cyc >= 0) chk("issue_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        int p, a, c, n0, nd;
        int ports[16];
        int k[3];
        rstn = 1'b1;
        bus.flush_in = 1'b0; bus.disp_valid_in = 1'b0; bus.opcode_in = '0; bus.funct3_in = '0;
        bus.rd_in = '0; bus.rs1_in = '0; bus.rs2_in = '0; bus.rs1_rdy_in = 1'b0;
        bus.rs2_rdy_in = 1'b0; bus.rs1_val_in = '0; bus.rs2_val_in = '0; bus.imm_in = '0;
        bus.cdb_valid_in = '0; bus.cdb_tag_in = '0; bus.cdb_value_in = '0; bus.fu_ready_in = '0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.disp_ready_out), 64'd0);
        chk("rst_count", 64'(bus.count_out), 64'd0);
        chk("rst_empty", 64'(bus.empty_out), 64'd1);
        chk("rst_full", 64'(bus.full_out), 64'd0);
        chk("rst_issue_valid", 64'(bus.issue_valid_out), 64'd0);
        rstn = 1'b0;
        #1;
        chk("ready_after_rst", 64'(bus.disp_ready_out), 64'd1);
        @(negedge clk);

        // ADD with both operands from the ARF
        bus.fu_ready_in = 3'b111;
        disp(7'h33, 3'd0, 6'd5, 6'd1, 6'd2, 1'b1, 1'b1, 32'd3, 32'd4, 32'd0, p, a);
        chk("add_port", 64'(p), 64'd0);
        push(p, 4'd1, 6'd5, 32'd3, 32'd4, 32'd0, a + 2);
        drain("add_drain");

        // XOR waits on rs1=9, woken by CDB0 two cycles later
        disp(7'h33, 3'd4, 6'd6, 6'd9, 6'd3, 1'b0, 1'b1, 32'd0, 32'd7, 32'd0, p, a);
        push(p, 4'd5, 6'd6, 32'hAA, 32'd7, 32'd0, a + 4);
        @(negedge clk);
        bus.cdb_valid_in = 3'b001; bus.cdb_tag_in[5:0] = 6'd9; bus.cdb_value_in[31:0] = 32'hAA;
        @(negedge clk);
        bus.cdb_valid_in = '0;
        drain("wakeup_drain");

        // LW with same-cycle bypass; duplicate tag on bus 2 must lose to bus 1
        bus.cdb_valid_in = 3'b110;
        bus.cdb_tag_in[11:6] = 6'd12; bus.cdb_tag_in[17:12] = 6'd12;
        bus.cdb_value_in[63:32] = 32'h55; bus.cdb_value_in[95:64] = 32'h77;
        disp(7'h03, 3'd2, 6'd7, 6'd12, 6'd0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h10, p, a);
        bus.cdb_valid_in = '0;
        push(p, 4'd8, 6'd7, 32'h55, 32'd0, 32'h10, a + 2);
        drain("bypass_drain");

        // Fill to RS_SIZE with FUs stalled; covers the decode table
        bus.fu_ready_in = 3'b000;
        for (int i = 0; i < RS; i++) begin
            disp(t_opc[i % 11], t_f3[i % 11], 6'(i), 6'(i + 20), 6'(i + 40), 1'b1, 1'b1,
                 32'(i * 3), 32'(i + 100), 32'(i << 4), p, a);
            ports[i] = p;
        end
        chk("full_count", 64'(bus.count_out), 64'(RS));
        chk("full_flag", 64'(bus.full_out), 64'd1);
        chk("full_ready", 64'(bus.disp_ready_out), 64'd0);
        chk("full_empty", 64'(bus.empty_out), 64'd0);
        // Dispatch attempt while full, in the same cycle the FUs open
        bus.opcode_in = 7'h33; bus.funct3_in = 3'd0; bus.rd_in = 6'd63;
        bus.rs1_rdy_in = 1'b1; bus.rs2_rdy_in = 1'b1;
        bus.disp_valid_in = 1'b1;
        bus.fu_ready_in = 3'b111;
        c = cyc;
        k[0] = 0; k[1] = 0; k[2] = 0;
        for (int i = 0; i < RS; i++) begin
            push(ports[i], t_op[i % 11], 6'(i), 32'(i * 3), 32'(i + 100), 32'(i << 4),
                 c + 1 + k[ports[i]]);
            k[ports[i]]++;
        end
        @(negedge clk);
        bus.disp_valid_in = 1'b0;
        chk("full_issue_count", 64'(bus.count_out), 64'(RS - 3));
        drain("fill_drain");
        chk("drained_count", 64'(bus.count_out), 64'd0);
        chk("drained_empty", 64'(bus.empty_out), 64'd1);

        // Three ready uops on FU0 with only FU0 open: one per cycle, in order
        bus.fu_ready_in = 3'b000;
        n0 = 0;
        nd = 0;
        while (n0 < 3) begin
            disp(7'h13, 3'd0, 6'(40 + nd), 6'd1, 6'd2, 1'b1, 1'b1, 32'(nd), 32'(nd + 50),
                 32'(nd * 2), p, a);
            ports[nd] = p;
            if (p == 0) n0++;
            nd++;
        end
        bus.fu_ready_in = 3'b001;
        c = cyc;
        k[0] = 0;
        for (int i = 0; i < nd; i++) begin
            if (ports[i] == 0) begin
                push(0, 4'd2, 6'(40 + i), 32'(i), 32'(i + 50), 32'(i * 2), c + 1 + k[0]);
                k[0]++;
            end else begin
                push(ports[i], 4'd2, 6'(40 + i), 32'(i), 32'(i + 50), 32'(i * 2), -1);
            end
        end
        repeat (5) @(negedge clk);
        bus.fu_ready_in = 3'b111;
        drain("fu0_drain");

        // Flush with 5 queued and a simultaneous dispatch
        bus.fu_ready_in = 3'b000;
        for (int i = 0; i < 5; i++) begin
            disp(7'h33, 3'd0, 6'(50 + i), 6'd1, 6'd2, 1'b1, 1'b1, 32'd1, 32'd2, 32'd0, p, a);
        end
        chk("pre_flush_count", 64'(bus.count_out), 64'd5);
        bus.flush_in = 1'b1;
        bus.disp_valid_in = 1'b1;
        bus.fu_ready_in = 3'b111;
        #1;
        chk("flush_ready", 64'(bus.disp_ready_out), 64'd0);
        @(negedge clk);
        bus.flush_in = 1'b0;
        bus.disp_valid_in = 1'b0;
        chk("flush_count", 64'(bus.count_out), 64'd0);
        chk("flush_empty", 64'(bus.empty_out), 64'd1);
        chk("flush_no_issue", 64'(bus.issue_valid_out), 64'd0);
        repeat (4) @(negedge clk);

        // rr_ptr survives flush: next dispatch lands on exp_rr
        disp(7'h37, 3'd0, 6'd33, 6'd0, 6'd0, 1'b1, 1'b1, 32'd9, 32'd8, 32'h1000, p, a);
        push(p, 4'd3, 6'd33, 32'd9, 32'd8, 32'h1000, a + 2);
        drain("post_flush_drain");

        // Reset mid-operation drops queued uops and rewinds rr_ptr
        bus.fu_ready_in = 3'b000;
        for (int i = 0; i < 2; i++) begin
            disp(7'h33, 3'd0, 6'(60 + i), 6'd1, 6'd2, 1'b1, 1'b1, 32'd1, 32'd2, 32'd0, p, a);
        end
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        exp_rr = 0;
        chk("midrst_count", 64'(bus.count_out), 64'd0);
        bus.fu_ready_in = 3'b111;
        repeat (3) @(negedge clk);
        disp(7'h23, 3'd2, 6'd21, 6'd4, 6'd5, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'h8, p, a);
        push(0, 4'd10, 6'd21, 32'h1234, 32'h5678, 32'h8, a + 2);
        drain("midrst_drain");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
